// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: strobe-sampled VGA timing monitor.
// Recovers pixel coordinates from hsync/vsync, checks line and frame lengths,
// locks after LOCK_FRAMES consecutive good frames and sums the visible colour
// of every complete locked frame.
module vga_sync_receiver #(
   parameter int H_ACTIVE        = 640,
   parameter int H_FP            = 16,
   parameter int H_SYNC          = 96,
   parameter int H_BP            = 48,
   parameter int V_ACTIVE        = 480,
   parameter int V_FP            = 10,
   parameter int V_SYNC          = 2,
   parameter int V_BP            = 33,
   parameter bit SYNC_ACTIVE_LOW = 1'b1,
   parameter int LOCK_FRAMES     = 2
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_pix_en,
   input  logic        i_hsync,
   input  logic        i_vsync,
   input  logic [11:0] i_rgb,
   input  logic        i_err_clr,
   output logic [9:0]  o_x,
   output logic [8:0]  o_y,
   output logic        o_active,
   output logic        o_locked,
   output logic        o_frame_start,
   output logic        o_h_err,
   output logic        o_v_err,
   output logic [15:0] o_frame_sum,
   output logic        o_frame_sum_valid
);

   localparam int          H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int          V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [9:0]  H_LAST  = 10'(H_TOTAL - 1);
   localparam logic [9:0]  H_START = 10'(H_SYNC + H_BP);
   localparam logic [9:0]  H_END   = 10'(H_SYNC + H_BP + H_ACTIVE);
   localparam logic [9:0]  V_START = 10'(V_SYNC + V_BP);
   localparam logic [9:0]  V_END   = 10'(V_SYNC + V_BP + V_ACTIVE);
   localparam logic [10:0] V_LEN   = 11'(V_TOTAL);
   localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);
   localparam logic [9:0]  CNT_MAX = 10'd1023;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      ACQUIRE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t      r_state;
   logic [9:0]  r_h_cnt;
   logic [9:0]  r_v_cnt;
   logic        r_hs_prev;
   logic        r_vs_prev;
   logic        r_bad_line;
   logic [3:0]  r_good_cnt;
   logic [15:0] r_acc;

   logic        w_hs_lvl;
   logic        w_vs_lvl;
   logic        w_hs_start;
   logic        w_vs_start;
   logic [9:0]  w_h_nxt;
   logic [9:0]  w_v_nxt;
   logic [10:0] w_v_len;
   logic        w_line_bad;
   logic        w_frame_good;
   logic        w_active;
   logic [15:0] w_acc_nxt;
   logic [3:0]  w_good_inc;

   // Edge detection, next counter values and line/frame judgements for the current strobe
   always_comb begin
      w_hs_lvl   = SYNC_ACTIVE_LOW ? ~i_hsync : i_hsync;
      w_vs_lvl   = SYNC_ACTIVE_LOW ? ~i_vsync : i_vsync;
      w_hs_start = w_hs_lvl & ~r_hs_prev;
      w_vs_start = w_vs_lvl & ~r_vs_prev;

      if (w_hs_start)
         w_h_nxt = '0;
      else if (r_h_cnt == CNT_MAX)
         w_h_nxt = r_h_cnt;
      else
         w_h_nxt = r_h_cnt + 10'd1;

      // vsync edge overrides the line increment when both land on one strobe
      if (w_vs_start)
         w_v_nxt = '0;
      else if (w_hs_start && (r_v_cnt != CNT_MAX))
         w_v_nxt = r_v_cnt + 10'd1;
      else
         w_v_nxt = r_v_cnt;

      // The line closed by a simultaneous hsync edge counts toward the frame length
      w_v_len      = {1'b0, r_v_cnt} + {10'd0, w_hs_start};
      w_line_bad   = (r_state != SEARCH) && w_hs_start && (r_h_cnt != H_LAST);
      w_frame_good = (w_v_len == V_LEN) && !r_bad_line && !w_line_bad;

      w_active   = (r_state == LOCKED) &&
                   (w_h_nxt >= H_START) && (w_h_nxt < H_END) &&
                   (w_v_nxt >= V_START) && (w_v_nxt < V_END);
      w_acc_nxt  = r_acc + (w_active ? {4'd0, i_rgb} : 16'd0);
      w_good_inc = r_good_cnt + 4'd1;
   end

   // Strobe-gated counters, lock FSM, sticky errors, coordinates and checksum
   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         r_state           <= SEARCH;
         r_h_cnt           <= '0;
         r_v_cnt           <= '0;
         r_hs_prev         <= 1'b0;
         r_vs_prev         <= 1'b0;
         r_bad_line        <= 1'b0;
         r_good_cnt        <= '0;
         r_acc             <= '0;
         o_x               <= '0;
         o_y               <= '0;
         o_active          <= 1'b0;
         o_locked          <= 1'b0;
         o_frame_start     <= 1'b0;
         o_h_err           <= 1'b0;
         o_v_err           <= 1'b0;
         o_frame_sum       <= '0;
         o_frame_sum_valid <= 1'b0;
      end else begin
         o_frame_start     <= 1'b0;
         o_frame_sum_valid <= 1'b0;
         if (i_pix_en) begin
            r_hs_prev     <= w_hs_lvl;
            r_vs_prev     <= w_vs_lvl;
            r_h_cnt       <= w_h_nxt;
            r_v_cnt       <= w_v_nxt;
            r_acc         <= w_acc_nxt;
            o_active      <= w_active;
            o_x           <= w_active ? (w_h_nxt - H_START) : '0;
            o_y           <= w_active ? 9'(w_v_nxt - V_START) : '0;
            o_frame_start <= w_vs_start;

            // Clear first so an error detected on the same strobe wins
            if (i_err_clr) begin
               o_h_err <= 1'b0;
               o_v_err <= 1'b0;
            end
            if (w_line_bad)
               r_bad_line <= 1'b1;

            case (r_state)
               SEARCH: begin
                  if (w_vs_start) begin
                     r_good_cnt <= '0;
                     r_state    <= ACQUIRE;
                  end
               end
               ACQUIRE: begin
                  if (w_vs_start) begin
                     if (!w_frame_good) begin
                        r_good_cnt <= '0;
                     end else begin
                        r_good_cnt <= w_good_inc;
                        if (w_good_inc >= LOCK_N) begin
                           r_state  <= LOCKED;
                           o_locked <= 1'b1;
                        end
                     end
                  end
               end
               LOCKED: begin
                  if (w_line_bad)
                     o_h_err <= 1'b1;
                  if (w_vs_start && !w_frame_good)
                     o_v_err <= 1'b1;
                  if (w_line_bad || (w_vs_start && !w_frame_good)) begin
                     r_state  <= SEARCH;
                     o_locked <= 1'b0;
                  end else if (w_vs_start) begin
                     o_frame_sum       <= w_acc_nxt;
                     o_frame_sum_valid <= 1'b1;
                  end
               end
               default: begin
                  r_state  <= SEARCH;
                  o_locked <= 1'b0;
               end
            endcase

            // Every frame boundary starts a fresh accumulation and bad-line history
            if (w_vs_start) begin
               r_acc      <= '0;
               r_bad_line <= 1'b0;
            end
         end
      end
   end

endmodule
